uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter.
- Sits between the external RS-232 RX pin and the on-chip control/debug logic.
- Baud rate is selectable from the same 8-entry table the transmitter uses.
- Delivers each received byte through a valid/ack handshake, with framing-error and overrun reporting.

Parameters:
- UART_CLK_MHZ, 50, clk frequency in MHz.
  - Divisor N = 1000000*UART_CLK_MHZ/baud - 1, integer division.
  - One bit period is N+1 clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- baud_sel_i  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
- rs232_rx_i  in  1  serial input; asynchronous to clk; idle high.
- rx_ack_i  in  1  consumer acknowledge of the held byte.
- rx_data_o  out  8  last good received byte.
- rx_valid_o  out  1  rx_data_o holds an unacknowledged byte.
- rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun_o  out  1  one-cycle pulse: good byte completed while rx_valid_o was already high.
- rx_busy_o  out  1  state != IDLE.

Behaviour:
- Reset values:
  - rx_data_o = 0; rx_valid_o, rx_frame_err_o, rx_overrun_o, rx_busy_o = 0.
  - Synchronizer flops = 1; state = IDLE; counters = 0.
- Input path: 2-flop synchronizer plus one history flop.
  - Falling edge = history 1 and synced 0.
  - Detection occurs 3 clk after the pin edge.
- Baud latch: divisor N is computed from baud_sel_i and registered on start detection. Changes to baud_sel_i mid-frame have no effect.
- Counters:
  - Bit-period counter cnt, 13 bits, counts 0..N.
  - Bit index, 3 bits, counts 0..7.
- State machine:
  - IDLE: cnt=0. On falling edge: latch N, go to START.
  - START: cnt increments each clk. At cnt==(N>>1), sample line.
    - Line low: cnt=0, go to DATA.
    - Line high: glitch; go to IDLE, no outputs.
  - DATA: at cnt==N, sample into shift register LSB-first, cnt=0, bit index +1. After the 8th sample, go to STOP.
  - STOP: at cnt==N, sample line.
    - High: go to IDLE and complete the byte.
    - Low: pulse rx_frame_err_o, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synced line is high, then go to IDLE. This prevents break conditions from re-triggering.
- Byte completion: on the clk after the stop sample:
  - rx_data_o <= shift register.
  - rx_valid_o <= 1.
  - If rx_valid_o was already 1 and rx_ack_i is not asserted in that same cycle, pulse rx_overrun_o. The new byte still overwrites rx_data_o.
- Handshake:
  - rx_valid_o clears on the clk after rx_ack_i is high.
  - If ack and completion coincide, completion wins: rx_valid_o stays 1 with the new data, and there is no overrun.
  - rx_ack_i while rx_valid_o=0 is ignored.
- Timing:
  - Every sample is taken at the bit centre ±1 clk.
  - rx_valid_o rises (N>>1) + 9*(N+1) + 2 clk after the synced falling edge.
- Back-to-back frames: the next falling edge is accepted from the first IDLE cycle. No extra idle time is required beyond the stop-bit centre.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial byte is lost.

Test Plan:
- Decode at 115200 (N=433, 50 MHz): drive 0xA5 with 434-clk bits.
  - rx_data_o=0xA5, rx_valid_o=1.
  - rx_valid_o rises exactly 216+9*434+2 clk after the synced start edge.
  - rx_frame_err_o never pulses.
- Baud sweep: sel=0 (N=5207) with 0x3C, then sel=7 (N=53) with 0xC3.
  - Both bytes decode correctly.
  - Changing baud_sel_i mid-frame does not corrupt the frame in progress.
- Glitch and framing error:
  - 100-clk low pulse on the line: no rx_valid_o, FSM returns to IDLE.
  - Frame 0x55 with stop bit low: one-cycle rx_frame_err_o, rx_data_o unchanged, rx_valid_o unchanged. No new start is accepted until the line goes high.
- Handshake and overrun:
  - Two back-to-back frames 0x11, 0x22 with no ack: one rx_overrun_o pulse, rx_data_o=0x22.
  - Ack in the same cycle as a completion: no overrun pulse, rx_valid_o stays 1.
  - Ack alone: rx_valid_o drops the next clk.
- Reset mid-frame: assert rst_n=0 during DATA bit 4.
  - Outputs return to reset values immediately.
  - Next clean frame 0xFF decodes correctly.
- Loopback: connect the team's transmitter output to rs232_rx_i, sel=4, send 0x00..0xFF. All 256 bytes are received in order with no errors.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with per-frame baud latch, valid/ack byte handshake,
// and one-cycle framing-error / overrun pulses.
module uart_rx #(
  parameter int UART_CLK_MHZ = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_sel_i,
  input  logic       rs232_rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       rx_busy_o
);

  localparam int unsigned CLK_HZ = 32'd1_000_000 * UART_CLK_MHZ;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  function automatic logic [12:0] baud_div(input logic [2:0] sel);
    logic [12:0] div;
    case (sel)
      3'd0:    div = 13'(CLK_HZ / 32'd9600   - 32'd1);
      3'd1:    div = 13'(CLK_HZ / 32'd19200  - 32'd1);
      3'd2:    div = 13'(CLK_HZ / 32'd38400  - 32'd1);
      3'd3:    div = 13'(CLK_HZ / 32'd57600  - 32'd1);
      3'd4:    div = 13'(CLK_HZ / 32'd115200 - 32'd1);
      3'd5:    div = 13'(CLK_HZ / 32'd230400 - 32'd1);
      3'd6:    div = 13'(CLK_HZ / 32'd460800 - 32'd1);
      3'd7:    div = 13'(CLK_HZ / 32'd921600 - 32'd1);
      default: div = 13'(CLK_HZ / 32'd9600   - 32'd1);
    endcase
    return div;
  endfunction

  logic        sync1_q;
  logic        sync2_q;
  logic        hist_q;
  state_t      state_q;
  logic [12:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [12:0] div_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        busy_q;

  logic [12:0] div_d;
  logic [12:0] half_s;
  logic        fall_s;

  assign div_d  = baud_div(baud_sel_i);
  assign half_s = {1'b0, div_q[12:1]};
  assign fall_s = hist_q & ~sync2_q;

  // Two-flop synchronizer for the asynchronous pin plus a history flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Frame state machine, bit timing, byte completion and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 13'd0;
      bit_idx_q   <= 3'd0;
      div_q       <= 13'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A completion later in this block overrides this clear
      if (rx_ack_i && valid_q) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          cnt_q     <= 13'd0;
          bit_idx_q <= 3'd0;
          if (fall_s) begin
            div_q   <= div_d;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == half_s) begin
            cnt_q <= 13'd0;
            if (!sync2_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == div_q) begin
            cnt_q     <= 13'd0;
            shift_q   <= {sync2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == div_q) begin
            cnt_q <= 13'd0;
            if (sync2_q) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              data_q    <= shift_q;
              valid_q   <= 1'b1;
              overrun_q <= valid_q & ~rx_ack_i;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        S_WAIT_IDLE: begin
          // Hold off through a break so a held-low line cannot start a new frame
          if (sync2_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 13'd0;
        end
      endcase
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = frame_err_q;
  assign rx_overrun_o   = overrun_q;
  assign rx_busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks with a byte scoreboard,
// plus a 1 MHz instance fed by a bench-side transmitter for the loopback sweep.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic [2:0] baud_sel;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       ov;
  logic       busy;

  logic       lb_rx;
  logic       lb_ack;
  logic [7:0] lb_data;
  logic       lb_valid;
  logic       lb_fe;
  logic       lb_ov;
  logic       lb_busy;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int lb_fe_cnt = 0;
  int lb_ov_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] lb_q[$];

  uart_rx #(.UART_CLK_MHZ(50)) dut (
    .clk(clk), .rst_n(rst_n), .baud_sel_i(baud_sel), .rs232_rx_i(rx), .rx_ack_i(ack),
    .rx_data_o(data), .rx_valid_o(valid), .rx_frame_err_o(fe), .rx_overrun_o(ov), .rx_busy_o(busy)
  );

  // 1 MHz clock scale: sel=4 gives N=7, 8 clocks per bit
  uart_rx #(.UART_CLK_MHZ(1)) u_lb (
    .clk(clk), .rst_n(rst_n), .baud_sel_i(3'd4), .rs232_rx_i(lb_rx), .rx_ack_i(lb_ack),
    .rx_data_o(lb_data), .rx_valid_o(lb_valid), .rx_frame_err_o(lb_fe), .rx_overrun_o(lb_ov),
    .rx_busy_o(lb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count cycles in which the pulse outputs are high
  always @(posedge clk) begin
    if (fe) fe_cnt <= fe_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if (lb_fe) lb_fe_cnt <= lb_fe_cnt + 1;
    if (lb_ov) lb_ov_cnt <= lb_ov_cnt + 1;
  end

  // Bench transmitter: start, 8 data LSB-first, stop; leaves the line at the stop level
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk, input bit to_lb);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (to_lb) lb_rx = f[i];
      else rx = f[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (fe !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b want 0", fe); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_ov: got %b want 0", ov); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: busy %b valid %b want 0 0", busy, valid);
    end
  endtask

  task automatic test_decode_115200();
    int fe0;
    logic [7:0] e;
    baud_sel = 3'd4;
    @(negedge clk);
    fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 434, 1'b0);
      begin
        // synced edge lands 2 clocks after the pin edge; valid due 216+9*434+2 later
        repeat (4125) @(posedge clk);
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL valid_early: got %b want 0", valid); end
        @(posedge clk);
        #1;
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL valid_rise_time: got %b want 1", valid); end
      end
    join
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL decode_a5: data %h valid %b want %h 1", data, valid, e);
    end
    n_vec++; if (fe_cnt != fe0) begin n_err++; $display("FAIL decode_fe: got %0d pulses want 0", fe_cnt - fe0); end
    ack_pulse();
  endtask

  task automatic test_baud_sweep();
    logic [7:0] e;
    baud_sel = 3'd0;
    @(negedge clk);
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C, 1'b1, 5208, 1'b0);
      begin
        repeat (3 * 5208) @(negedge clk);
        baud_sel = 3'd7;
      end
    join
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL sweep_9600: data %h valid %b want %h 1", data, valid, e);
    end
    ack_pulse();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 54, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL sweep_921600: data %h valid %b want %h 1", data, valid, e);
    end
    ack_pulse();
  endtask

  task automatic test_glitch();
    baud_sel = 3'd4;
    @(negedge clk);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b want 1", busy); end
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || valid !== 1'b0 || data !== 8'hC3) begin
      n_err++; $display("FAIL glitch_reject: busy %b valid %b data %h want 0 0 c3", busy, valid, data);
    end
    baud_sel = 3'd7;
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 54, 1'b0);
    repeat (200) @(negedge clk);
    n_vec++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt - fe0); end
    n_vec++; if (data !== 8'hC3 || valid !== 1'b0) begin
      n_err++; $display("FAIL frame_err_hold: data %h valid %b want c3 0", data, valid);
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_wait: busy %b want 1", busy); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || fe_cnt - fe0 != 1) begin
      n_err++; $display("FAIL break_release: busy %b fe %0d want 0 1", busy, fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [7:0] e;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 54, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: data %h valid %b want %h 1", data, valid, e);
    end
    send_frame(8'h22, 1'b1, 54, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: data %h valid %b want %h 1", data, valid, e);
    end
    n_vec++; if (ov_cnt - ov0 != 1) begin n_err++; $display("FAIL overrun_pulse: got %0d want 1", ov_cnt - ov0); end
  endtask

  task automatic test_ack_coincide();
    int ov0;
    logic [7:0] e;
    ov0 = ov_cnt;
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1, 54, 1'b0);
      begin
        // completion edge is posedge 26+4+9*54 = 516 after the start bit is driven
        repeat (515) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL ack_coincide: data %h valid %b want %h 1", data, valid, e);
    end
    n_vec++; if (ov_cnt != ov0) begin n_err++; $display("FAIL ack_coincide_ov: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_ack_alone();
    ack = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ack_clear: valid %b want 0", valid); end
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    ack_pulse();
    @(negedge clk);
    n_vec++; if (valid !== 1'b0 || data !== 8'h33) begin
      n_err++; $display("FAIL ack_idle: valid %b data %h want 0 33", valid, data);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] e;
    fork
      send_frame(8'h96, 1'b1, 54, 1'b0);
      begin
        repeat (5 * 54 + 27) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: busy %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || fe !== 1'b0 || ov !== 1'b0) begin
          n_err++; $display("FAIL midframe_reset: data %h valid %b busy %b fe %b ov %b want 00 0 0 0 0",
                            data, valid, busy, fe, ov);
        end
      end
    join
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 54, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (data !== e || valid !== 1'b1) begin
      n_err++; $display("FAIL after_reset_ff: data %h valid %b want %h 1", data, valid, e);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] e;
    int got;
    got = 0;
    @(negedge clk);
    for (int b = 0; b < 256; b++) begin
      lb_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 8, 1'b1);
      e = lb_q.pop_front();
      n_vec++;
      if (lb_valid !== 1'b1 || lb_data !== e) begin
        n_err++; $display("FAIL loopback_byte: data %h valid %b want %h 1", lb_data, lb_valid, e);
      end else begin
        got++;
      end
      lb_ack = 1'b1;
      @(negedge clk);
      lb_ack = 1'b0;
    end
    n_vec++; if (got != 256) begin n_err++; $display("FAIL loopback_count: got %0d want 256", got); end
    n_vec++; if (lb_fe_cnt != 0 || lb_ov_cnt != 0) begin
      n_err++; $display("FAIL loopback_errors: fe %0d ov %0d want 0 0", lb_fe_cnt, lb_ov_cnt);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    baud_sel = 3'd4;
    rx       = 1'b1;
    ack      = 1'b0;
    lb_rx    = 1'b1;
    lb_ack   = 1'b0;
    test_reset();
    test_decode_115200();
    test_baud_sweep();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_ack_coincide();
    test_ack_alone();
    test_reset_midframe();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
